// File: rtl/amns_pkg.sv
// Shared AMNS definitions: host-sequencer state encoding and the operand/result BRAM address map.
// Both the host sequencer and the controller derive their sizes and bases from here.
package amns_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_LOAD     = 3'd0;
  localparam seq_state_t ST_CORE_RST = 3'd1;
  localparam seq_state_t ST_START    = 3'd2;
  localparam seq_state_t ST_WAIT     = 3'd3;
  localparam seq_state_t ST_RD_ISSUE = 3'd4;
  localparam seq_state_t ST_RD_WAIT  = 3'd5;
  localparam seq_state_t ST_OUT      = 3'd6;

  // M'_0 sits at the bottom; the result later overwrites M'_0/M from address 0.
  localparam int MP0_BASE = 0;

  function automatic int load_words(input int n, input int s);
    return 3 * n * s + n;
  endfunction

  function automatic int res_words(input int n, input int s);
    return n * s;
  endfunction

  function automatic int addr_w(input int n, input int s);
    return $clog2(4 * n * s);
  endfunction

  function automatic int m_base(input int n);
    return n;
  endfunction

  function automatic int a_base(input int n, input int s);
    return n * s + n;
  endfunction

  function automatic int b_base(input int n, input int s);
    return 2 * n * s + n;
  endfunction

endpackage

// File: rtl/amns_host_sequencer.sv
// Host sequencer for the AMNS core: streams operands into the shared BRAM on port B,
// runs one job on the core, then streams the result words back out.
module amns_host_sequencer
  import amns_pkg::*;
#(
  parameter int s      = 5,
  parameter int N      = 5,
  parameter int WORD_W = 64,
  parameter int RD_LAT = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WORD_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WORD_W-1:0]        out_data_o,
  output logic                     core_reset_o,
  output logic                     core_start_o,
  input  logic                     core_done_i,
  output logic                     bram_en_o,
  output logic                     bram_we_o,
  output logic [addr_w(N, s)-1:0]  bram_addr_o,
  output logic [WORD_W-1:0]        bram_wdata_o,
  input  logic [WORD_W-1:0]        bram_rdata_i,
  output logic                     busy_o
);

  localparam int LOAD_WORDS = load_words(N, s);
  localparam int RES_WORDS  = res_words(N, s);
  localparam int AW         = addr_w(N, s);
  localparam int LW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_WORDS - 1);
  localparam logic [AW-1:0] RES_LAST  = AW'(RES_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(RD_LAT - 1);

  seq_state_t        state_q;
  logic [AW-1:0]     load_cnt_q;
  logic [AW-1:0]     rd_cnt_q;
  logic [LW-1:0]     lat_cnt_q;
  logic [WORD_W-1:0] out_data_q;
  logic              in_hs;

  // Gating with reset_i keeps a mid-load reset from leaking a write onto port B.
  assign in_ready_o   = (state_q == ST_LOAD) && !reset_i;
  assign in_hs        = in_valid_i && in_ready_o;
  assign out_valid_o  = (state_q == ST_OUT);
  assign out_data_o   = out_data_q;
  assign core_reset_o = reset_i || (state_q == ST_CORE_RST);
  assign core_start_o = (state_q == ST_START);
  assign busy_o       = (state_q != ST_LOAD);

  always_comb begin
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    if (in_hs) begin
      bram_en_o    = 1'b1;
      bram_we_o    = 1'b1;
      bram_addr_o  = load_cnt_q;
      bram_wdata_o = in_data_i;
    end else if (state_q == ST_RD_ISSUE) begin
      bram_en_o   = 1'b1;
      bram_addr_o = rd_cnt_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            if (load_cnt_q == LOAD_LAST) begin
              load_cnt_q <= '0;
              state_q    <= ST_CORE_RST;
            end else begin
              load_cnt_q <= load_cnt_q + AW'(1);
            end
          end
        end
        ST_CORE_RST: state_q <= ST_START;
        ST_START:    state_q <= ST_WAIT;
        ST_WAIT: begin
          if (core_done_i) begin
            rd_cnt_q <= '0;
            state_q  <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          lat_cnt_q <= LAT_LOAD;
          state_q   <= ST_RD_WAIT;
        end
        // Down-counter expires on the cycle the BRAM data is valid.
        ST_RD_WAIT: begin
          if (lat_cnt_q == '0) begin
            out_data_q <= bram_rdata_i;
            state_q    <= ST_OUT;
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            if (rd_cnt_q == RES_LAST) begin
              rd_cnt_q <= '0;
              state_q  <= ST_LOAD;
            end else begin
              rd_cnt_q <= rd_cnt_q + AW'(1);
              state_q  <= ST_RD_ISSUE;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_amns_host_sequencer.sv
// Bench for amns_host_sequencer: behavioural BRAM and controller, plus a job-timeline model
// compared against the DUT every cycle.
module tb_amns_host_sequencer;

  localparam int RD_LAT = 2;
  localparam int LOADN  = 80;
  localparam int RESN   = 25;
  localparam int PH_LOAD = 0;
  localparam int PH_SEQ  = 1;
  localparam int PH_RD   = 2;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] out_data_o;
  logic        core_reset_o;
  logic        core_start_o;
  logic        core_done_i;
  logic        bram_en_o;
  logic        bram_we_o;
  logic [6:0]  bram_addr_o;
  logic [63:0] bram_wdata_o;
  logic [63:0] bram_rdata_i;
  logic        busy_o;

  amns_host_sequencer #(.s(5), .N(5), .WORD_W(64), .RD_LAT(RD_LAT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .core_reset_o(core_reset_o), .core_start_o(core_start_o), .core_done_i(core_done_i),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus / scenario controls
  int in_mode = 0;
  int out_mode = 0;
  int stall_left = 0;
  int job_idx = 0;
  int jobs_done = 0;
  bit glitch_en = 0;
  bit in_rst = 1;

  // model state
  int m_ph = PH_LOAD, m_load = 0, m_k = 0, m_word = 0, m_j = 0;
  int wr_seen = 0, cyc = 0, last_hs_cyc = 0, bad = 0;
  bit post_rst_chk = 0;
  logic [63:0] exp_mem [0:LOADN-1];
  logic e_rdy, e_busy, e_crst, e_start, e_ov, e_en, e_we;
  logic [6:0]  e_addr;
  logic [63:0] e_wd;

  // behavioural BRAM + controller
  logic [63:0] mem   [0:127];
  logic [63:0] rpipe [0:RD_LAT-1];
  logic [63:0] res   [0:RESN-1];
  logic ctl_done = 1'b0;
  logic glitch = 1'b0;
  int   done_cnt = 0;

  assign core_done_i  = ctl_done | glitch;
  assign bram_rdata_i = rpipe[RD_LAT-1];

  always @(posedge clock_i) begin
    cyc <= cyc + 1;
    if (bram_en_o && bram_we_o) mem[bram_addr_o] <= bram_wdata_o;
    rpipe[0] <= (bram_en_o && !bram_we_o) ? mem[bram_addr_o] : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (core_reset_o) begin
      ctl_done <= 1'b0;
      done_cnt <= 0;
    end else if (core_start_o) begin
      done_cnt <= 50;
    end else if (done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) begin
        ctl_done <= 1'b1;
        for (int i = 0; i < RESN; i++) mem[i] <= res[i];
      end
    end
  end

  // input drivers, applied just after each rising edge
  always @(posedge clock_i) begin
    #1;
    case (in_mode)
      0:       in_valid_i = 1'b1;
      1:       in_valid_i = !in_valid_i;
      default: in_valid_i = 1'($urandom_range(0, 1));
    endcase
    in_data_i = (in_mode < 2) ? 64'(100 + m_load) : {$urandom, $urandom};
    if (out_mode == 1 && m_word == 3 && out_valid_o && stall_left > 0) begin
      out_ready_i = 1'b0;
      stall_left--;
    end else if (out_mode == 2) begin
      out_ready_i = 1'($urandom_range(0, 1));
    end else begin
      out_ready_i = 1'b1;
    end
    glitch = glitch_en && (core_reset_o || (in_ready_o && $urandom_range(0, 3) == 0));
  end

  // per-cycle comparison against the job timeline, then advance the timeline
  always @(negedge clock_i) begin
    if (!in_rst) begin
      e_rdy = 0; e_busy = 1; e_crst = 0; e_start = 0; e_ov = 0; e_en = 0; e_we = 0;
      e_addr = '0; e_wd = '0;
      case (m_ph)
        PH_LOAD: begin
          e_rdy = 1; e_busy = 0;
          if (in_valid_i) begin e_en = 1; e_we = 1; e_addr = 7'(m_load); e_wd = in_data_i; end
        end
        PH_SEQ: begin e_crst = (m_k == 1); e_start = (m_k == 2); end
        default: begin
          if (m_j == 0) begin e_en = 1; e_addr = 7'(m_word); end
          e_ov = (m_j > RD_LAT);
        end
      endcase
      chk1("in_ready", in_ready_o, e_rdy);
      chk1("busy", busy_o, e_busy);
      chk1("core_reset", core_reset_o, e_crst);
      chk1("core_start", core_start_o, e_start);
      chk1("out_valid", out_valid_o, e_ov);
      chk1("bram_en", bram_en_o, e_en);
      chk1("bram_we", bram_we_o, e_we);
      chk64("bram_addr", 64'(bram_addr_o), 64'(e_addr));
      chk64("bram_wdata", bram_wdata_o, e_wd);
      if (e_ov) chk64("out_data", out_data_o, res[m_word]);
      if (bram_en_o && bram_we_o) wr_seen++;

      if (job_idx == 0 && m_ph == PH_LOAD && in_valid_i && m_load == 0)
        chk64("first_wdata", bram_wdata_o, 64'd100);
      if (job_idx == 0 && m_ph == PH_LOAD && in_valid_i && m_load == 79) begin
        chk64("last_addr", 64'(bram_addr_o), 64'd79);
        chk64("last_wdata", bram_wdata_o, 64'd179);
      end
      if (post_rst_chk && bram_en_o && bram_we_o) begin
        chk64("addr_after_reset", 64'(bram_addr_o), 64'd0);
        post_rst_chk = 0;
      end
      if (job_idx == 0 && e_ov && out_ready_i) begin
        if (m_word == 0)  chk64("first_result", out_data_o, 64'hA0);
        if (m_word == 24) chk64("last_result", out_data_o, 64'hB8);
        if (m_word > 0)   chk64("result_spacing", 64'(cyc - last_hs_cyc), 64'd4);
        last_hs_cyc = cyc;
      end

      case (m_ph)
        PH_LOAD: begin
          if (in_valid_i) begin
            exp_mem[m_load] = in_data_i;
            m_load++;
            if (m_load == LOADN) begin m_ph = PH_SEQ; m_k = 1; m_load = 0; end
          end
        end
        PH_SEQ: begin
          if (m_k == 1) begin
            bad = 0;
            for (int i = 0; i < LOADN; i++) if (mem[i] !== exp_mem[i]) bad++;
            chk64("bram_contents_bad", 64'(bad), 64'd0);
            chk64("writes_per_job", 64'(wr_seen), 64'd80);
            wr_seen = 0;
          end
          if (m_k >= 3 && core_done_i) begin m_ph = PH_RD; m_word = 0; m_j = 0; end
          else m_k++;
        end
        default: begin
          if (m_j > RD_LAT && out_ready_i) begin
            if (m_word == RESN - 1) begin m_ph = PH_LOAD; jobs_done++; end
            else begin m_word++; m_j = 0; end
          end else if (m_j <= RD_LAT) begin
            m_j++;
          end
        end
      endcase
    end
  end

  task automatic rst_vals();
    chk1("rst_core_reset", core_reset_o, 1'b1);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_core_start", core_start_o, 1'b0);
    chk1("rst_bram_en", bram_en_o, 1'b0);
    chk1("rst_bram_we", bram_we_o, 1'b0);
    chk1("rst_in_ready", in_ready_o, 1'b0);
    chk64("rst_bram_addr", 64'(bram_addr_o), 64'd0);
    chk64("rst_bram_wdata", bram_wdata_o, 64'd0);
    chk64("rst_out_data", out_data_o, 64'd0);
  endtask

  task automatic new_results();
    for (int i = 0; i < RESN; i++) res[i] = {$urandom, $urandom};
  endtask

  initial begin
    for (int i = 0; i < RESN; i++) res[i] = 64'hA0 + 64'(i);
    #1 reset_i = 1'b1;
    #2 rst_vals();
    @(posedge clock_i); @(posedge clock_i); #3;
    reset_i = 1'b0; in_rst = 0;

    wait (jobs_done >= 1);
    in_mode = 1; out_mode = 1; stall_left = 10; job_idx = 1; new_results();

    wait (jobs_done >= 2);
    in_mode = 0; out_mode = 0; glitch_en = 1; job_idx = 2; new_results();
    wait (m_ph == PH_LOAD && m_load == 40);
    @(posedge clock_i); #3;
    reset_i = 1'b1; in_rst = 1;
    #1 rst_vals();
    @(posedge clock_i); @(posedge clock_i); #3;
    m_ph = PH_LOAD; m_load = 0; wr_seen = 0; post_rst_chk = 1;
    reset_i = 1'b0; in_rst = 0;

    wait (jobs_done >= 3);
    in_mode = 2; out_mode = 2; job_idx = 3; new_results();
    wait (jobs_done >= 4);
    job_idx = 4; new_results();
    wait (jobs_done >= 5);
    @(posedge clock_i); #2;
    chk1("idle_busy", busy_o, 1'b0);
    chk1("idle_in_ready", in_ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clock_i);
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: jobs_done %0d expected 5", jobs_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
